// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter that drives the 8:1 data mux select lines.
package rr_mux_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Decode a requester index into a one-hot vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin pick: first unmasked request at or after ptr, wrapping.
module rr_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0]   masked;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [SEL_W-1:0]   offset;

  assign masked  = req & ~mask;
  assign doubled = {masked, masked} >> ptr;
  assign rotated = doubled[N_REQ-1:0];

  // Lowest set bit of the rotated vector is the first request at or after ptr.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = SEL_W'(i);
      end
    end
  end

  assign idx = offset + ptr;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with per-grant hold limit; registered one-hot grant and mux select.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [SEL_W-1:0]  sel_d;
  logic              valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [SEL_W-1:0]  next_idx;
  logic [SEL_W-1:0]  pick_ptr;
  logic [N_REQ-1:0]  pick_mask;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;

  // While granted, search starts past the owner with the owner excluded.
  assign next_idx  = sel + SEL_W'(1);
  assign pick_ptr  = (state_q == ST_GRANT) ? next_idx : ptr_q;
  assign pick_mask = (state_q == ST_GRANT) ? onehot(sel) : '0;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      valid   <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    valid_d = valid;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
          valid_d = 1'b1;
          hold_d  = HOLD_ONE;
        end
      end
      ST_GRANT: begin
        if (!req[sel]) begin
          ptr_d = next_idx;
          if (pick_found) begin
            gnt_d  = onehot(pick_idx);
            sel_d  = pick_idx;
            hold_d = HOLD_ONE;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_MAX)) begin
          // Hold limit reached: rotate if anyone else is waiting, else restart the count.
          hold_d = HOLD_ONE;
          if (pick_found) begin
            gnt_d = onehot(pick_idx);
            sel_d = pick_idx;
            ptr_d = next_idx;
          end
        end else if ((MAX_HOLD != 0) && (hold_q < HOLD_MAX)) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: reference model plus directed literal expectations.
module tb_rr_mux_arbiter;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;

  int checks;
  int errors;

  rr_mux_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit m_valid;
  int m_sel;
  int m_ptr;
  int m_hold;

  function automatic int find(input logic [7:0] r, input int start, input int excl);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (start + k) % 8;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_sel = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_valid) begin
      int w;
      w = find(req, m_ptr, -1);
      if (w >= 0) begin m_valid = 1; m_sel = w; m_hold = 1; end
    end else begin
      int o, w;
      o = m_sel;
      if (!req[o]) begin
        m_ptr = (o + 1) % 8;
        w = find(req, m_ptr, o);
        if (w >= 0) begin m_sel = w; m_hold = 1; end
        else m_valid = 0;
      end else if (MAXH != 0 && m_hold == MAXH) begin
        w = find(req, (o + 1) % 8, o);
        m_hold = 1;
        if (w >= 0) begin m_sel = w; m_ptr = (o + 1) % 8; end
      end else if (MAXH != 0) begin
        m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] exp_gnt;
    exp_gnt = m_valid ? 8'(1 << m_sel) : 8'h00;
    check("model_gnt", 32'(gnt), 32'(exp_gnt));
    check("model_valid", 32'(valid), 32'(m_valid));
    check("model_sel", 32'(sel), 32'(m_sel));
    check("inv_valid_or", 32'(valid), 32'(|gnt));
  end

  // Apply a request vector at a falling edge and wait one full cycle.
  task automatic cyc(input logic [7:0] r);
    req = r;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [7:0] g, input logic [2:0] s, input logic v);
    check({name, "_gnt"}, 32'(gnt), 32'(g));
    check({name, "_sel"}, 32'(sel), 32'(s));
    check({name, "_valid"}, 32'(valid), 32'(v));
  endtask

  logic [7:0] seq5 [12];
  logic [7:0] vec_tbl [16];

  initial begin
    checks = 0;
    errors = 0;
    seq5 = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h20, 8'h20, 8'h20, 8'h20,
             8'h08, 8'h08, 8'h08, 8'h08};
    vec_tbl = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'hFF, 8'hFE, 8'hFC, 8'h81, 8'h81, 8'h01, 8'h18, 8'h00};
    rst = 1'b1;
    req = 8'h00;
    repeat (2) @(negedge clk);
    expect_out("reset", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;

    // Single requester: 1-cycle latency, release keeps sel
    cyc(8'h10);
    expect_out("single", 8'h10, 3'd4, 1'b1);
    cyc(8'h00);
    expect_out("single_rel", 8'h00, 3'd4, 1'b0);

    // All requesting from ptr=5, then asynchronous reset mid-grant
    cyc(8'hFF);
    expect_out("all_req", 8'h20, 3'd5, 1'b1);
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    req = 8'h00;
    rst = 1'b0;
    cyc(8'h00);
    expect_out("post_rst0", 8'h00, 3'd0, 1'b0);
    cyc(8'h00);
    expect_out("post_rst1", 8'h00, 3'd0, 1'b0);

    // Back-to-back rotation with no idle gap
    cyc(8'h0A);
    expect_out("rot_a", 8'h02, 3'd1, 1'b1);
    cyc(8'h08);
    expect_out("rot_b1", 8'h08, 3'd3, 1'b1);
    cyc(8'h02);
    expect_out("rot_b2", 8'h02, 3'd1, 1'b1);
    cyc(8'h00);
    expect_out("rot_idle", 8'h00, 3'd1, 1'b0);

    // Hold expiry alternates every MAX_HOLD cycles
    for (int i = 0; i < 12; i++) begin
      cyc(8'h28);
      check($sformatf("hold_seq%0d", i), 32'(gnt), 32'(seq5[i]));
    end
    cyc(8'h00);
    expect_out("hold_idle", 8'h00, 3'd3, 1'b0);

    // Sole requester keeps the grant past the limit; then wrap 7->0
    for (int i = 0; i < 10; i++) begin
      cyc(8'h80);
      check($sformatf("sole%0d", i), 32'(gnt), 32'h80);
    end
    cyc(8'h81);
    expect_out("sole_keep", 8'h80, 3'd7, 1'b1);
    cyc(8'h01);
    expect_out("wrap", 8'h01, 3'd0, 1'b1);
    cyc(8'h00);
    expect_out("wrap_idle", 8'h00, 3'd0, 1'b0);

    // Extra directed vectors checked by the model only
    for (int i = 0; i < 16; i++) cyc(vec_tbl[i]);
    cyc(8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares the team's 8:1 gate-level data mux among eight requesters. It registers a one-hot grant and drives the mux select lines directly: S0=sel[0], S1=sel[1], S2=sel[2]. A per-grant hold counter bounds how long one requester can own the channel. The mux output is meaningful only while valid=1.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 to match the mux width.
SEL_W, 3, select width, log2(N_REQ).
MAX_HOLD, 4, maximum consecutive grant cycles before a forced rotation. 0 means unlimited.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  8  request vector. Bit i is held high while requester i wants the mux.
gnt  out  8  registered one-hot grant. All zero when idle.
sel  out  3  registered mux select, index of the current or last owner.
valid  out  1  registered; 1 while a grant is active.

Behaviour:
- Reset (async, active-high): gnt=0, sel=0, valid=0, ptr=0, hold_cnt=0, state=IDLE. Reset asserted mid-grant drops the grant immediately, with no completion of the transfer.
- The pick function scans req starting at index ptr, upward, wrapping 7->0. The first set bit wins.
- States: IDLE and GRANT, two-state FSM.
- IDLE, any req set:
  - pick winner w; next cycle gnt=onehot(w), sel=w, valid=1, hold_cnt=1, state->GRANT.
  - Latency is 1 cycle from req to gnt.
- IDLE, no req: hold all outputs; sel keeps its last value.
- GRANT, owner o=sel:
  - (a) req[o]=0 (release): ptr=o+1 mod 8.
    - If any other req is set, re-pick from o+1 in the same cycle. The new grant appears next cycle with no idle gap and hold_cnt=1.
    - Otherwise gnt=0, valid=0, state->IDLE, sel unchanged.
  - (b) req[o]=1 and MAX_HOLD!=0 and hold_cnt==MAX_HOLD:
    - if any other req bit is set, pick from o+1 with o masked out; the winner is granted next cycle, ptr=o+1, hold_cnt=1.
    - if no other req, o keeps the grant and hold_cnt restarts at 1.
  - (c) otherwise: keep the grant; hold_cnt increments, saturating at MAX_HOLD.
- Req changes on non-owners never preempt before the hold limit.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt==onehot(sel) whenever valid=1.
  - valid==|gnt.
- hold_cnt width is clog2(MAX_HOLD+1), minimum 1 bit.
- ptr wraps modulo 8; sel+1 wraps 7->0.
- All outputs are registered; no combinational path from req to outputs.

Decomposition:
- Shared package holds: N_REQ=8, SEL_W=3, state encoding (ST_IDLE=1'b0, ST_GRANT=1'b1), and a onehot-decode function.
- One natural sub-module, rr_pick (combinational):
  - inputs: req[7:0], ptr[2:0], mask[7:0].
  - outputs: found, idx[2:0].
  - Implemented as rotate, priority-encode, un-rotate.
- Top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
1. Reset: assert rst mid-run with req=8'hFF -> gnt=0, sel=0, valid=0 asynchronously. After release with req=8'h00, outputs stay 0.
2. Single requester: req=8'h10 at cycle 0 -> cycle 1 gnt=8'h10, sel=4, valid=1. Drop req -> next cycle gnt=0, valid=0, sel=4.
3. Back-to-back rotation, sequence A: req=8'h0A (1 and 3) from IDLE with ptr=0 -> grant 1.
4. Back-to-back rotation, sequence B: requester 1 drops -> grant 3 the next cycle with no gap. Requester 3 drops while req=8'h02 -> grant 1 again (pick starts at 4 and wraps).
5. Hold expiry (MAX_HOLD=4): req=8'h28 held constant -> grant alternates 3,3,3,3,5,5,5,5,3 and so on. gnt changes exactly every 4 cycles.
6. Sole requester at limit plus wrap: req=8'h80 held for 10 cycles -> gnt=8'h80 throughout, with hold_cnt restarting. Then req=8'h81 and 7 drops -> grant 0 (wrap 7->0), sel=0.
